sd_request_arbiter: RTL

Shares the single SD-card image channel (sd_bus_control toward the MiSTer HPS block-I/O host) between several block-level requesters: floppy controller drives, tape image and the ROM/state loader. Each requester issues whole-sector read or write commands with an LBA. The arbiter grants one requester at a time in round-robin order and drives the SD command handshake. It holds the grant until the host reports the transfer complete, and steers the sector data strobes to the owner. It sits between the peripheral devices and the top-level sd_bus / sd_bus_control instances.

---
 rtl/sd_request_arbiter_if.sv | 49 ++++
 rtl/sd_request_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/sd_request_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : sd_request_arbiter_if
//  Description : Bundle of the requester-side and host-side signals of the
//                SD image channel arbiter.
//                slave  modport : seen from the arbiter
//                master modport : seen from the requesters and host
//  Ports       : req_rd/req_wr/req_lba      requester commands (level)
//                req_done/req_err           completion pulses to requesters
//                grant_valid/grant_id       current channel owner
//                sd_rd/sd_wr/sd_lba         command toward the host
//                sd_ack/sd_done/sd_buff_wr  host handshake and data strobe
//                own_buff_wr                data strobe steered to the owner
//  Revision    : 1.0 - initial release
// ============================================================================
interface sd_request_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int LBA_W   = 32
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_rd;
    logic [NUM_REQ-1:0]            req_wr;
    logic [NUM_REQ-1:0][LBA_W-1:0] req_lba;
    logic [NUM_REQ-1:0]            req_done;
    logic [NUM_REQ-1:0]            req_err;
    logic                          grant_valid;
    logic [ID_W-1:0]               grant_id;
    logic                          sd_rd;
    logic                          sd_wr;
    logic [LBA_W-1:0]              sd_lba;
    logic                          sd_ack;
    logic                          sd_done;
    logic                          sd_buff_wr;
    logic [NUM_REQ-1:0]            own_buff_wr;

    modport slave (
        input  req_rd, req_wr, req_lba, sd_ack, sd_done, sd_buff_wr,
        output req_done, req_err, grant_valid, grant_id,
               sd_rd, sd_wr, sd_lba, own_buff_wr
    );

    modport master (
        output req_rd, req_wr, req_lba, sd_ack, sd_done, sd_buff_wr,
        input  req_done, req_err, grant_valid, grant_id,
               sd_rd, sd_wr, sd_lba, own_buff_wr
    );
endinterface
`default_nettype wire

// File: rtl/sd_request_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sd_request_arbiter
//  Description : Round-robin owner of the single SD image channel. Grants one
//                block requester at a time, drives the host command
//                handshake, holds the grant until the host reports the sector
//                transfer done and steers the host data strobe to the owner.
//                A watchdog aborts a command the host never acknowledges.
//  Ports       : clk_sys  - system clock, rising edge
//                reset_n  - asynchronous reset, active low
//                bus      - sd_request_arbiter_if.slave (requesters + host)
//  Revision    : 1.0 - initial release
// ============================================================================
module sd_request_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int LBA_W   = 32,
    parameter int TIMEOUT = 2**20
) (
    input  wire logic             clk_sys,
    input  wire logic             reset_n,
    sd_request_arbiter_if.slave   bus
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam int WD_W = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0] ID_LAST = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_BUSY    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_q, rr_d;
    logic [ID_W-1:0]   gid_q, gid_d;
    logic [LBA_W-1:0]  lba_q, lba_d;
    logic              op_rd_q, op_rd_d;
    logic              err_q, err_d;
    logic [WD_W-1:0]   wd_q, wd_d;

    logic [NUM_REQ-1:0] w_pend;
    logic               w_found;
    logic [ID_W-1:0]    w_win;
    logic [ID_W:0]      w_sum;
    logic [ID_W-1:0]    w_cand;

    assign w_pend = bus.req_rd | bus.req_wr;

    // Scan from the round-robin pointer upward; the sum never exceeds
    // 2*(NUM_REQ-1), so one conditional subtraction performs the wrap.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        w_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, rr_q} + (ID_W+1)'(k);
            if (w_sum >= (ID_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (ID_W+1)'(NUM_REQ);
            end
            w_cand = w_sum[ID_W-1:0];
            if (!w_found && w_pend[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gid_d   = gid_q;
        lba_d   = lba_q;
        op_rd_d = op_rd_q;
        err_d   = err_q;
        wd_d    = wd_q;
        case (state_q)
            S_IDLE: begin
                if (w_found) begin
                    gid_d   = w_win;
                    lba_d   = bus.req_lba[w_win];
                    // Read takes priority when both levels are set.
                    op_rd_d = bus.req_rd[w_win];
                    err_d   = 1'b0;
                    wd_d    = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // An sd_done coinciding with the ack is deliberately dropped.
                if (bus.sd_ack) begin
                    state_d = S_BUSY;
                end else if (wd_q == WD_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_RELEASE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            S_BUSY: begin
                if (bus.sd_done) begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                rr_d    = (gid_q == ID_LAST) ? '0 : gid_q + ID_W'(1);
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            gid_q   <= '0;
            lba_q   <= '0;
            op_rd_q <= 1'b0;
            err_q   <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gid_q   <= gid_d;
            lba_q   <= lba_d;
            op_rd_q <= op_rd_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
        end
    end

    // Outputs decode directly from registered state so an asynchronous
    // reset clears them without waiting for a clock edge.
    assign bus.grant_valid = (state_q != S_IDLE);
    assign bus.grant_id    = gid_q;
    assign bus.sd_rd       = (state_q == S_ISSUE) &&  op_rd_q;
    assign bus.sd_wr       = (state_q == S_ISSUE) && !op_rd_q;
    assign bus.sd_lba      = lba_q;

    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
            logic w_owner;
            assign w_owner             = (gid_q == ID_W'(i));
            assign bus.req_done[i]     = (state_q == S_RELEASE) && w_owner;
            assign bus.req_err[i]      = (state_q == S_RELEASE) && w_owner && err_q;
            assign bus.own_buff_wr[i]  = bus.sd_buff_wr && (state_q != S_IDLE) && w_owner;
        end
    endgenerate

endmodule
`default_nettype wire
